// File: rtl/dsp_audio_pkg.sv
// Shared audio-path definitions: sample and I2S slot widths, sample type.
package dsp_audio_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned SLOT_W   = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with registered full/empty/level status.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   push, push_data  write request and data (ignored while full)
//   pop              read request (ignored while empty)
//   head_c           current head entry, combinational from storage
//   full, empty      registered status
//   level            registered occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo
  import dsp_audio_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head_c,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LVL_W-1:0] level_n;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_c  = mem[rd_ptr];

  // Occupancy after this edge; simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_n = level;
    if (do_push && !do_pop) begin
      level_n = level + LVL_W'(1);
    end else if (do_pop && !do_push) begin
      level_n = level - LVL_W'(1);
    end
  end

  // Pointers and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_n;
      full  <= (level_n == LVL_W'(DEPTH));
      empty <= (level_n == '0);
    end
  end

  // Storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S (Philips) transmitter for the DAC output. Each frame carries one mono
// sample left-justified into both the left and right 24-bit slots; an empty
// FIFO at frame start sends silence and flags underrun.
// Ports:
//   clk, reset       system clock, asynchronous active-low reset
//   sample_i         filtered sample, two's complement
//   sample_valid_i   sample_i valid this cycle
//   sample_ready_o   FIFO can accept a sample
//   bclk_o           bit clock, period 2*BCLK_DIV clk
//   lrclk_o          word select, 0 = left slot
//   sdata_o          serial data, MSB first, one BCLK after the lrclk edge
//   underrun_o       one-clk pulse: frame started with FIFO empty
//   fifo_level_o     FIFO occupancy
module i2s_dac_tx
  import dsp_audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SAMPLE_W-1:0]         sample_i,
  input  logic                        sample_valid_i,
  output logic                        sample_ready_o,
  output logic                        bclk_o,
  output logic                        lrclk_o,
  output logic                        sdata_o,
  output logic                        underrun_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
  localparam int unsigned FRAME_BITS = 2 * SLOT_W;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam int unsigned PAD_W      = SLOT_W - SAMPLE_W;

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_cnt_n;
  logic [FRAME_BITS-1:0] shreg;
  logic                  div_tc;
  logic                  fall_tick;
  logic                  frame_start;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  sample_t               fifo_head;

  // All data and word-select updates happen on the BCLK falling tick.
  assign div_tc      = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign fall_tick   = div_tc && bclk_o;
  assign frame_start = fall_tick && (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign bit_cnt_n   = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);

  // Status is registered inside the FIFO, so ready follows it directly.
  assign fifo_pop       = frame_start && !fifo_empty;
  assign sample_ready_o = !fifo_full;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (sample_valid_i),
    .push_data (sample_i),
    .pop       (fifo_pop),
    .head_c    (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_o)
  );

  // BCLK divider, frame counter, shift register and 1-bit output stage.
  // sdata_o takes the MSB before the shift, which yields the I2S one-bit delay:
  // the last right-slot bit leaves during the first BCLK of the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt    <= '0;
      bclk_o     <= 1'b0;
      lrclk_o    <= 1'b1;
      sdata_o    <= 1'b0;
      underrun_o <= 1'b0;
      bit_cnt    <= BIT_W'(FRAME_BITS - 1);
      shreg      <= '0;
    end else begin
      underrun_o <= 1'b0;
      div_cnt    <= div_tc ? '0 : div_cnt + DIV_W'(1);
      if (div_tc) bclk_o <= !bclk_o;
      if (fall_tick) begin
        bit_cnt <= bit_cnt_n;
        lrclk_o <= (bit_cnt_n >= BIT_W'(SLOT_W));
        sdata_o <= shreg[FRAME_BITS-1];
        if (frame_start) begin
          // Silence on underrun rather than repeating the previous sample.
          underrun_o <= fifo_empty;
          shreg      <= fifo_empty ? '0
                        : {fifo_head, PAD_W'(0), fifo_head, PAD_W'(0)};
        end else begin
          shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: a bit-level I2S receiver model decodes
// each frame at BCLK rising edges, and directed vectors/sequences compare the
// decoded slots and status outputs with hand-computed values.
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_i;
  logic        sample_valid_i;
  logic        sample_ready_o;
  logic        bclk_o;
  logic        lrclk_o;
  logic        sdata_o;
  logic        underrun_o;
  logic [2:0]  fifo_level_o;

  always #5 clk = ~clk;

  i2s_dac_tx #(
    .BCLK_DIV   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .bclk_o         (bclk_o),
    .lrclk_o        (lrclk_o),
    .sdata_o        (sdata_o),
    .underrun_o     (underrun_o),
    .fifo_level_o   (fifo_level_o)
  );

  typedef struct {
    logic [15:0] sample;
    logic [23:0] exp_slot;
  } vec_t;

  vec_t vecs [6];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  longint      cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: samples sdata/lrclk at each BCLK rise; a frame is complete
  // at the first rise after lrclk falls (that rise carries the right-slot LSB).
  logic        bclk_q;
  logic        lr_q;
  logic [47:0] hist;
  int          bits_seen;
  logic [23:0] lq [$];
  logic [23:0] rq [$];
  int          und_cnt = 0;
  longint      und_t [$];

  always @(negedge clk) begin
    if (!reset) begin
      bclk_q    = 1'b0;
      lr_q      = 1'b1;
      hist      = '0;
      bits_seen = 0;
      lq.delete();
      rq.delete();
    end else begin
      if (underrun_o) begin
        und_cnt++;
        und_t.push_back(cyc);
      end
      if (bclk_o && !bclk_q) begin
        hist = {hist[46:0], sdata_o};
        bits_seen++;
        if (lr_q && !lrclk_o) begin
          if (bits_seen >= 48) begin
            lq.push_back(hist[47:24]);
            rq.push_back(hist[23:0]);
          end
          bits_seen = 0;
        end
        lr_q = lrclk_o;
      end
      bclk_q = bclk_o;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [47:0] rec(input int idx);
    if (idx < lq.size()) return {lq[idx], rq[idx]};
    return 48'hBAD0_BAD0_BAD0;
  endfunction

  // Advance to the negedge just after the next underrun pulse (frame start, FIFO empty).
  task automatic sync_frame(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!underrun_o && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_sync_underrun"}, 64'(underrun_o), 64'd1);
  endtask

  task automatic wait_recs(input int need, input string name);
    int k;
    k = 0;
    while (lq.size() < need && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_frames_arrived"}, 64'(lq.size() >= need), 64'd1);
  endtask

  initial begin
    int base;
    int n_bclk, n_lr, n_und, n_sd;
    logic pb, pl;
    logic [15:0] s4 [6];
    int acc, guard;
    logic rdy;
    int und0;

    vecs[0] = '{16'hA5C3, 24'hA5C300};
    vecs[1] = '{16'h8000, 24'h800000};
    vecs[2] = '{16'h7FFF, 24'h7FFF00};
    vecs[3] = '{16'h0001, 24'h000100};
    vecs[4] = '{16'hFFFF, 24'hFFFF00};
    vecs[5] = '{16'h1234, 24'h123400};

    reset          = 1'b1;
    sample_i       = '0;
    sample_valid_i = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_bclk",  64'(bclk_o),         64'd0);
    chk("rst_lrclk", 64'(lrclk_o),        64'd1);
    chk("rst_sdata", 64'(sdata_o),        64'd0);
    chk("rst_under", 64'(underrun_o),     64'd0);
    chk("rst_ready", 64'(sample_ready_o), 64'd1);
    chk("rst_level", 64'(fifo_level_o),   64'd0);

    // First BCLK rise 4 clks after release, first frame start at clk 8.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("bclk_before_first_rise", 64'(bclk_o), 64'd0);
    @(negedge clk);
    chk("bclk_first_rise", 64'(bclk_o), 64'd1);
    repeat (3) @(negedge clk);
    chk("bclk_high_clk7",  64'(bclk_o),  64'd1);
    chk("lrclk_high_clk7", 64'(lrclk_o), 64'd1);
    @(negedge clk);
    chk("bclk_fall_clk8",     64'(bclk_o),     64'd0);
    chk("lrclk_left_clk8",    64'(lrclk_o),    64'd0);
    chk("underrun_first_frame", 64'(underrun_o), 64'd1);
    @(negedge clk);
    chk("underrun_one_clk", 64'(underrun_o), 64'd0);

    // Idle: 768 clks -> 192 BCLK toggles, 4 lrclk toggles, 2 underruns, no data.
    n_bclk = 0; n_lr = 0; n_und = 0; n_sd = 0;
    pb = bclk_o; pl = lrclk_o;
    for (int i = 0; i < 768; i++) begin
      @(negedge clk);
      if (bclk_o != pb) n_bclk++;
      if (lrclk_o != pl) n_lr++;
      if (underrun_o) n_und++;
      if (sdata_o) n_sd++;
      pb = bclk_o; pl = lrclk_o;
    end
    chk("idle_bclk_toggles",  64'(n_bclk), 64'd192);
    chk("idle_lrclk_toggles", 64'(n_lr),   64'd4);
    chk("idle_underruns",     64'(n_und),  64'd2);
    chk("idle_sdata_ones",    64'(n_sd),   64'd0);
    if (und_t.size() >= 2)
      chk("underrun_period", 64'(und_t[und_t.size()-1] - und_t[und_t.size()-2]), 64'd384);
    else
      chk("underrun_period_count", 64'(und_t.size()), 64'd2);

    // Table: one sample per vector; frame after the push is silent, next carries it.
    for (int i = 0; i < 6; i++) begin
      sync_frame($sformatf("vec%0d", i));
      sample_i = vecs[i].sample;
      sample_valid_i = 1'b1;
      @(negedge clk);
      sample_valid_i = 1'b0;
      repeat (8) @(negedge clk);
      base = lq.size();
      wait_recs(base + 2, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_silent_frame", i), 64'(rec(base)), 64'd0);
      chk($sformatf("vec%0d_left", i),  64'(rec(base+1) >> 24), 64'(vecs[i].exp_slot));
      chk($sformatf("vec%0d_right", i), 64'(rec(base+1) & 48'hFF_FFFF), 64'(vecs[i].exp_slot));
    end

    // Back-to-back pushes: consecutive frames, no underrun until the FIFO drains.
    sync_frame("b2b");
    sample_valid_i = 1'b1;
    sample_i = 16'h8000;
    @(negedge clk);
    sample_i = 16'h7FFF;
    @(negedge clk);
    sample_valid_i = 1'b0;
    und0 = und_cnt;
    base = lq.size() + 1;
    wait_recs(base + 3, "b2b");
    chk("b2b_silent",  64'(rec(base)),   64'd0);
    chk("b2b_frame1",  64'(rec(base+1)), 64'h8000_0080_0000);
    chk("b2b_frame2",  64'(rec(base+2)), 64'h7FFF_007F_FF00);
    chk("b2b_underruns", 64'(und_cnt - und0), 64'd1);

    // Hold valid across 6 samples: 4 accepted, then stall until frames pop.
    s4[0] = 16'h1111; s4[1] = 16'h2222; s4[2] = 16'h3333;
    s4[3] = 16'h4444; s4[4] = 16'h5555; s4[5] = 16'h6666;
    sync_frame("full");
    base = lq.size() + 1;
    acc = 0;
    guard = 0;
    sample_i = s4[0];
    sample_valid_i = 1'b1;
    while (acc < 6 && guard < 3000) begin
      rdy = sample_ready_o;
      @(negedge clk);
      guard++;
      if (rdy) begin
        acc++;
        if (acc < 6) sample_i = s4[acc];
      end
      if (guard == 4) begin
        chk("full_ready_low", 64'(sample_ready_o), 64'd0);
        chk("full_level4",    64'(fifo_level_o),   64'd4);
      end
      if (guard == 200) chk("full_stalled", {32'(acc), 29'd0, fifo_level_o}, {32'd4, 29'd0, 3'd4});
    end
    sample_valid_i = 1'b0;
    chk("full_all_accepted", 64'(acc), 64'd6);
    wait_recs(base + 7, "full");
    chk("full_silent", 64'(rec(base)), 64'd0);
    for (int j = 0; j < 6; j++)
      chk($sformatf("full_frame%0d", j), 64'(rec(base+1+j)), 64'({s4[j], 8'h00, s4[j], 8'h00}));

    // Push coincident with frame start while empty: underrun, sample waits a frame.
    sync_frame("coinc");
    repeat (383) @(negedge clk);
    sample_i = 16'h5A5A;
    sample_valid_i = 1'b1;
    @(negedge clk);
    sample_valid_i = 1'b0;
    chk("coinc_underrun", 64'(underrun_o),   64'd1);
    chk("coinc_level",    64'(fifo_level_o), 64'd1);
    base = lq.size() + 1;
    wait_recs(base + 2, "coinc");
    chk("coinc_silent_frame", 64'(rec(base)),   64'd0);
    chk("coinc_next_frame",   64'(rec(base+1)), 64'h5A5A_005A_5A00);

    // Reset in the middle of the left slot with one sample still queued.
    sync_frame("midrst");
    sample_valid_i = 1'b1;
    sample_i = 16'h1357;
    @(negedge clk);
    sample_i = 16'h2468;
    @(negedge clk);
    sample_valid_i = 1'b0;
    repeat (440) @(negedge clk);
    chk("midrst_in_left", 64'(lrclk_o),      64'd0);
    chk("midrst_level1",  64'(fifo_level_o), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_bclk",  64'(bclk_o),         64'd0);
    chk("midrst_lrclk", 64'(lrclk_o),        64'd1);
    chk("midrst_sdata", 64'(sdata_o),        64'd0);
    chk("midrst_under", 64'(underrun_o),     64'd0);
    chk("midrst_ready", 64'(sample_ready_o), 64'd1);
    chk("midrst_level", 64'(fifo_level_o),   64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_level", 64'(fifo_level_o), 64'd0);
    repeat (7) @(negedge clk);
    chk("post_rst_underrun", 64'(underrun_o), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
